// File: rtl/sdram_pkg.sv
// Shared definitions for the CPU-to-SDRAM request bridge.
// Holds the FSM state encoding, access-size codes, the default SDRAM
// window base and the alignment helper used at request acceptance.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] SDRAM_WIN_BASE = 32'h0003_0000;

  // True when the low address bits do not match the natural alignment of size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sdram_bridge_stats.sv
// Saturating transaction counters for the SDRAM request bridge.
// Ports: clk, reset (sync, active-high); inc_rd/inc_wr/inc_err one-cycle
// increment strobes; stat_rd/stat_wr/stat_err CNT_W-bit saturating counts.
module sdram_bridge_stats
  import sdram_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_rd,
  input  logic             inc_wr,
  input  logic             inc_err,
  output logic [CNT_W-1:0] stat_rd,
  output logic [CNT_W-1:0] stat_wr,
  output logic [CNT_W-1:0] stat_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else begin
      if (inc_rd && (stat_rd != CNT_MAX))
        stat_rd <= stat_rd + CNT_W'(1);
      if (inc_wr && (stat_wr != CNT_MAX))
        stat_wr <= stat_wr + CNT_W'(1);
      if (inc_err && (stat_err != CNT_MAX))
        stat_err <= stat_err + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_req_bridge.sv
// CPU-side request front end for the SDRAM controller.
// Accepts one load/store at a time (cpu_req/cpu_ready), rejects out-of-window
// or misaligned requests locally, issues a single-cycle mem_rw_req, waits for
// mem_data_valid (bounded by TIMEOUT_CYCLES) and returns a one-cycle
// cpu_rvalid response, with cpu_err flagging window/alignment/timeout errors.
// Ports: clk, reset (sync, active-high); CPU side cpu_req, cpu_ready, cpu_we,
// cpu_addr, cpu_size, cpu_wdata, cpu_rvalid, cpu_rdata, cpu_err; controller
// side mem_rw_req, mem_rw, mem_address, mem_write_data, mem_size,
// mem_read_data, mem_data_valid.
// Optional: define SDRAM_BRIDGE_STATS_EN to add stat_rd/stat_wr/stat_err.
module sdram_req_bridge
  import sdram_pkg::*;
#(
  parameter logic [31:0] WIN_BASE       = SDRAM_WIN_BASE,
  parameter int unsigned TIMEOUT_CYCLES = 16384,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  output logic             cpu_ready,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [1:0]       cpu_size,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_err,
  output logic             mem_rw_req,
  output logic             mem_rw,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic [1:0]       mem_size,
  input  logic [31:0]      mem_read_data,
  input  logic             mem_data_valid
`ifdef SDRAM_BRIDGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_rd,
  output logic [CNT_W-1:0] stat_wr,
  output logic [CNT_W-1:0] stat_err
`endif
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] tmo_cnt;

  logic             req_fire_c;
  logic             req_bad_c;
  logic             timeout_c;

  logic             ready_d;
  logic             rvalid_d;
  logic             err_d;
  logic [31:0]      rdata_d;
  logic             rw_req_d;

  assign req_fire_c = cpu_req && cpu_ready;
  assign req_bad_c  = (cpu_addr < WIN_BASE) || cpu_addr[31] || (cpu_size == 2'd3) ||
                      misaligned(cpu_size, cpu_addr[1:0]);
  assign timeout_c  = (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; data_valid takes priority over a coincident timeout.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (req_fire_c) next_state = req_bad_c ? ST_ERR : ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (mem_data_valid) next_state = ST_RESP;
        else if (timeout_c) next_state = ST_ERR;
      end
      ST_RESP:  next_state = ST_IDLE;
      ST_ERR:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    ready_d  = (next_state == ST_IDLE);
    rvalid_d = (next_state == ST_RESP) || (next_state == ST_ERR);
    err_d    = (next_state == ST_ERR);
    rw_req_d = (next_state == ST_ISSUE);
    rdata_d  = '0;
    if ((state == ST_WAIT) && mem_data_valid && !mem_rw)
      rdata_d = mem_read_data;
  end

  // Response/handshake registers, request latch and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ready      <= 1'b1;
      cpu_rvalid     <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_rdata      <= '0;
      mem_rw_req     <= 1'b0;
      mem_rw         <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_size       <= '0;
      tmo_cnt        <= '0;
    end else begin
      cpu_ready  <= ready_d;
      cpu_rvalid <= rvalid_d;
      cpu_err    <= err_d;
      cpu_rdata  <= rdata_d;
      mem_rw_req <= rw_req_d;
      // mem_* hold from acceptance until the response leaves.
      if ((state == ST_IDLE) && req_fire_c) begin
        mem_rw         <= cpu_we;
        mem_address    <= cpu_addr;
        mem_write_data <= cpu_wdata;
        mem_size       <= cpu_size;
      end
      if (state == ST_ISSUE)
        tmo_cnt <= '0;
      else if (state == ST_WAIT)
        tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

`ifdef SDRAM_BRIDGE_STATS_EN
  logic inc_rd_c;
  logic inc_wr_c;
  logic inc_err_c;

  assign inc_rd_c  = (state == ST_WAIT) && (next_state == ST_RESP) && !mem_rw;
  assign inc_wr_c  = (state == ST_WAIT) && (next_state == ST_RESP) && mem_rw;
  assign inc_err_c = (state != ST_ERR) && (next_state == ST_ERR);

  sdram_bridge_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk      (clk),
    .reset    (reset),
    .inc_rd   (inc_rd_c),
    .inc_wr   (inc_wr_c),
    .inc_err  (inc_err_c),
    .stat_rd  (stat_rd),
    .stat_wr  (stat_wr),
    .stat_err (stat_err)
  );
`endif

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Self-checking bench for sdram_req_bridge: directed cases plus randomized
// requests, each checked against a transaction-level expectation computed
// from the address/size/latency rules.
module tb_sdram_req_bridge;

  localparam int          TMO  = 16384;
  localparam logic [31:0] BASE = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_ready;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_wdata;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_rw_req;
  logic        mem_rw;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_size;
  logic [31:0] mem_read_data;
  logic        mem_data_valid;
`ifdef SDRAM_BRIDGE_STATS_EN
  logic [15:0] stat_rd;
  logic [15:0] stat_wr;
  logic [15:0] stat_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;
  int exp_er   = 0;

  always #5 clk = ~clk;

  sdram_req_bridge #(
    .WIN_BASE       (BASE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_ready      (cpu_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_size       (cpu_size),
    .cpu_wdata      (cpu_wdata),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .cpu_err        (cpu_err),
    .mem_rw_req     (mem_rw_req),
    .mem_rw         (mem_rw),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_size       (mem_size),
    .mem_read_data  (mem_read_data),
    .mem_data_valid (mem_data_valid)
`ifdef SDRAM_BRIDGE_STATS_EN
    ,
    .stat_rd        (stat_rd),
    .stat_wr        (stat_wr),
    .stat_err       (stat_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request. dv_dly = cycles from the rw_req pulse to data_valid (<1 never).
  // Called and returns just after a rising edge with the bridge idle.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input int dv_dly, input logic [31:0] rd);
    logic        legal, timed_out, exp_err, got_err;
    logic [31:0] exp_rdata, got_rdata;
    int          resp_at, n_rw, rw_at, n_rv, rv_at;
    legal = (addr >= BASE) && (addr < 32'h8000_0000) && (size != 2'd3) &&
            ((addr % (32'd1 << size)) == 0);
    timed_out = legal && ((dv_dly < 1) || (dv_dly > TMO));
    if (!legal)        resp_at = 1;
    else if (timed_out) resp_at = TMO + 2;
    else               resp_at = dv_dly + 2;
    exp_err   = !legal || timed_out;
    exp_rdata = (exp_err || we) ? 32'h0 : rd;
    n_rw = 0; rw_at = 0; n_rv = 0; rv_at = 0; got_err = 1'bx; got_rdata = 'x;

    chk("ready_before", cpu_ready, 1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size; cpu_wdata = wdata;
    step();
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = $urandom; cpu_size = 2'($urandom); cpu_wdata = $urandom;
    for (int n = 1; n <= resp_at + 1; n++) begin
      if (mem_rw_req) begin n_rw++; rw_at = n; end
      if (cpu_rvalid) begin n_rv++; rv_at = n; got_err = cpu_err; got_rdata = cpu_rdata; end
      if ((n == 1) && legal) begin
        chk("mem_address", mem_address, addr);
        chk("mem_rw", mem_rw, we);
        chk("mem_size", mem_size, size);
        chk("mem_write_data", mem_write_data, wdata);
        chk("ready_busy", cpu_ready, 0);
      end
      if (n == resp_at + 1) chk("ready_after", cpu_ready, 1);
      mem_data_valid = (n == dv_dly + 1);
      mem_read_data  = (n == dv_dly + 1) ? rd : $urandom;
      if (n <= resp_at) step();
    end
    mem_data_valid = 1'b0;
    chk("rvalid_count", n_rv, 1);
    chk("rvalid_cycle", rv_at, resp_at);
    chk("resp_err", got_err, exp_err);
    chk("resp_rdata", got_rdata, exp_rdata);
    chk("rw_req_count", n_rw, legal ? 1 : 0);
    chk("rw_req_cycle", rw_at, legal ? 1 : 0);
    if (exp_err) exp_er++;
    else if (we) exp_wr++;
    else         exp_rd++;
  endtask

  initial begin
    int          rv_n, rw_n;
    int          rv_cyc[2];
    int          rw_cyc[2];
    logic [31:0] r_addr, r_data;
    logic [1:0]  r_size;

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = '0;
    cpu_wdata = '0; mem_read_data = '0; mem_data_valid = 1'b0;
    step(); step();
    chk("rst_ready", cpu_ready, 1);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_rw_req", mem_rw_req, 0);
    chk("rst_mem_rw", mem_rw, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_mem_size", mem_size, 0);
    reset = 1'b0;
    step();

    // Directed cases.
    run_txn(1'b0, 32'h0003_0010, 2'd2, 32'h0, 12, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h0003_0002, 2'd1, 32'h0000_1234, 4, 32'hCAFE_F00D);
    run_txn(1'b0, 32'h0002_FFFC, 2'd2, 32'h0, 3, 32'h1111_1111);
    run_txn(1'b0, 32'h8003_0000, 2'd2, 32'h0, 3, 32'h2222_2222);
    run_txn(1'b0, 32'h0003_0002, 2'd2, 32'h0, 3, 32'h3333_3333);
    run_txn(1'b1, 32'h0003_0000, 2'd3, 32'h5, 0, 32'h4444_4444);
    run_txn(1'b0, 32'h0003_0001, 2'd0, 32'h0, 1, 32'h0000_00A5);
    run_txn(1'b0, 32'h0003_0100, 2'd2, 32'h0, -1, 32'h5555_5555);
    run_txn(1'b0, 32'h0003_0104, 2'd2, 32'h0, TMO, 32'h6666_6666);

    // Reset while waiting, then a stray data_valid must be ignored.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0003_0200; cpu_size = 2'd2;
    step();
    cpu_req = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0; mem_data_valid = 1'b1; mem_read_data = 32'h7777_7777;
    exp_rd = 0; exp_wr = 0; exp_er = 0;
    step();
    mem_data_valid = 1'b0;
    chk("rst_mid_rvalid", cpu_rvalid, 0);
    chk("rst_mid_ready", cpu_ready, 1);
    chk("rst_mid_rw_req", mem_rw_req, 0);
    step();
    chk("rst_mid_rvalid2", cpu_rvalid, 0);
    run_txn(1'b0, 32'h0003_0300, 2'd2, 32'h0, 2, 32'h8888_8888);

    // Back-to-back: request held high, second one queued behind the first.
    rv_n = 0; rw_n = 0; rv_cyc = '{0, 0}; rw_cyc = '{0, 0};
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0003_0400; cpu_size = 2'd2;
    step();
    cpu_we = 1'b1; cpu_addr = 32'h0003_0408; cpu_size = 2'd1; cpu_wdata = 32'h0000_BEEF;
    for (int n = 1; n <= 15; n++) begin
      if (mem_rw_req) begin
        if (rw_n < 2) rw_cyc[rw_n] = n;
        rw_n++;
        if (n == 9) begin
          chk("b2b_addr2", mem_address, 32'h0003_0408);
          chk("b2b_rw2", mem_rw, 1);
        end
      end
      if (cpu_rvalid) begin
        if (rv_n < 2) rv_cyc[rv_n] = n;
        rv_n++;
        if (n == 7) chk("b2b_rdata1", cpu_rdata, 32'h0BAD_CAFE);
        if (n == 13) chk("b2b_rdata2", cpu_rdata, 32'h0);
      end
      if (n == 9) cpu_req = 1'b0;
      mem_data_valid = (n == 6) || (n == 12);
      mem_read_data  = (n == 6) ? 32'h0BAD_CAFE : $urandom;
      step();
    end
    mem_data_valid = 1'b0;
    chk("b2b_rw_count", rw_n, 2);
    chk("b2b_rw_cyc1", rw_cyc[0], 1);
    chk("b2b_rw_cyc2", rw_cyc[1], 9);
    chk("b2b_rv_count", rv_n, 2);
    chk("b2b_rv_cyc1", rv_cyc[0], 7);
    chk("b2b_rv_cyc2", rv_cyc[1], 13);
    exp_rd++; exp_wr++;

    // Randomized requests.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       r_addr = BASE + $urandom_range(0, 255);
        1:       r_addr = $urandom_range(0, 32'h0002_FFFF);
        2:       r_addr = 32'h8000_0000 | $urandom;
        default: r_addr = 32'h0004_0000 + ($urandom_range(0, 1023) << 2);
      endcase
      r_size = 2'($urandom_range(0, 3));
      r_data = $urandom;
      run_txn(1'($urandom_range(0, 1)), r_addr, r_size, $urandom,
              $urandom_range(1, 30), r_data);
    end

`ifdef SDRAM_BRIDGE_STATS_EN
    step();
    chk("stat_rd", 32'(stat_rd), exp_rd);
    chk("stat_wr", 32'(stat_wr), exp_wr);
    chk("stat_err", 32'(stat_err), exp_er);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
